vip_stream_reader: RTL

- Synthesizable read-side consumer of a VIP pixel FIFO, mirroring the FIFO write side that produces frames.
- Pops pixels from a normal-mode FIFO (data valid 1 cycle after rdreq) and re-emits them as a ready/valid pixel stream.
- Tags each pixel with start-of-frame, end-of-line and end-of-frame markers using latched width/height/num_frame.
- Sits between vip_top's output FIFO and downstream sinks: writer, display or DMA.

---
 rtl/vip_stream_reader_pkg.sv | 22 ++
 rtl/vip_stream_reader_skid2.sv | 56 +++++
 rtl/vip_stream_reader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/vip_stream_reader_pkg.sv
// Shared types and defaults for the VIP stream reader: FSM encoding and the
// per-pixel tag bundle that travels alongside pixel data.
package vip_stream_pkg;

  localparam int DIM_W_DEF  = 11;
  localparam int DWIDTH_DEF = 24;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/vip_stream_reader_skid2.sv
// Two-entry ready/valid buffer. Head drives the output and only changes when
// popped (or when empty), so data is stable while a beat is stalled.
module vip_stream_skid2 #(
  parameter int W = 27
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         valid,
  output logic [W-1:0] data,
  input  logic         ready,
  output logic [1:0]   occupancy
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic [1:0]   occ;
  logic         pop;

  assign pop       = valid && ready;
  assign valid     = (occ != 2'd0);
  assign data      = head;
  assign occupancy = occ;

  // Upstream never pushes into a full buffer unless a pop happens in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= push_data;
          else             tail <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vip_stream_reader.sv
// Pops pixels from a normal-mode VIP FIFO and re-emits them as a tagged
// ready/valid stream. Optional stall/starve counters: VIP_STREAM_READER_STALL_CNT_EN.
module vip_stream_reader
  import vip_stream_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [DIM_W-1:0]  num_frame,
  input  logic [DWIDTH-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rdreq,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              done,
`ifdef VIP_STREAM_READER_STALL_CNT_EN
  output logic [31:0]       stall_cycles,
  output logic [31:0]       starve_cycles,
`endif
  output state_t            fsm_state
);

  localparam int ACC_W = 3 * DIM_W;
  localparam int BUF_W = DWIDTH + TAG_W;

  state_t            state;
  state_t            state_nxt;
  logic [DIM_W-1:0]  w_q, h_q, nf_q;
  logic [DIM_W-1:0]  col, row, frm;
  logic              issue_done;
  logic              rd_pend;
  tag_t              pend_tag;
  tag_t              issue_tag;
  tag_t              buf_tag;
  logic [ACC_W-1:0]  total;
  logic [ACC_W-1:0]  acc_cnt;
  logic              dims_ok;
  logic              take_start;
  logic              last_issue;
  logic              last_accept;
  logic              buf_valid;
  logic              buf_pop;
  logic [BUF_W-1:0]  buf_data;
  logic [1:0]        buf_occ;
  logic [2:0]        load;

  assign dims_ok    = (|width) && (|height) && (|num_frame);
  assign take_start = (state == S_IDLE) && start;

  assign issue_tag.sof = (col == '0) && (row == '0);
  assign issue_tag.eol = (col == w_q - DIM_W'(1));
  assign issue_tag.eof = issue_tag.eol && (row == h_q - DIM_W'(1));
  assign last_issue    = issue_tag.eof && (frm == nf_q - DIM_W'(1));

  // Handshake: a beat transfers on out_valid && out_ready; once out_valid rises,
  // out_data and tags hold until that transfer. Room is judged after this
  // cycle's pop so a 1-deep steady state sustains one pixel per cycle.
  assign buf_pop    = buf_valid && out_ready;
  assign load       = {1'b0, buf_occ} - {2'b00, buf_pop} + {2'b00, rd_pend};
  assign fifo_rdreq = (state == S_RUN) && !fifo_empty && !issue_done && (load < 3'd2);

  assign last_accept = buf_pop && ((acc_cnt + ACC_W'(1)) == total);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = dims_ok ? S_RUN : S_DONE;
      S_RUN:  if (last_accept) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      w_q        <= '0;
      h_q        <= '0;
      nf_q       <= '0;
      col        <= '0;
      row        <= '0;
      frm        <= '0;
      issue_done <= 1'b0;
      rd_pend    <= 1'b0;
      pend_tag   <= '0;
      total      <= '0;
      acc_cnt    <= '0;
    end else begin
      state    <= state_nxt;
      rd_pend  <= fifo_rdreq;
      pend_tag <= issue_tag;
      if (take_start) begin
        w_q        <= width;
        h_q        <= height;
        nf_q       <= num_frame;
        total      <= ACC_W'(width) * ACC_W'(height) * ACC_W'(num_frame);
        col        <= '0;
        row        <= '0;
        frm        <= '0;
        issue_done <= 1'b0;
        acc_cnt    <= '0;
      end else begin
        if (fifo_rdreq) begin
          if (last_issue) issue_done <= 1'b1;
          if (issue_tag.eol) begin
            col <= '0;
            if (issue_tag.eof) begin
              row <= '0;
              frm <= frm + DIM_W'(1);
            end else begin
              row <= row + DIM_W'(1);
            end
          end else begin
            col <= col + DIM_W'(1);
          end
        end
        if (buf_pop) acc_cnt <= acc_cnt + ACC_W'(1);
      end
    end
  end

  // Tags were computed at issue time and ride alongside the FIFO read data.
  vip_stream_skid2 #(.W(BUF_W)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_pend),
    .push_data ({fifo_data, pend_tag}),
    .valid     (buf_valid),
    .data      (buf_data),
    .ready     (out_ready),
    .occupancy (buf_occ)
  );

  assign buf_tag   = buf_data[TAG_W-1:0];
  assign out_data  = buf_data[TAG_W +: DWIDTH];
  assign out_valid = buf_valid;
  assign out_sof   = buf_tag.sof;
  assign out_eol   = buf_tag.eol;
  assign out_eof   = buf_tag.eof;
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign fsm_state = state;

`ifdef VIP_STREAM_READER_STALL_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles  <= '0;
      starve_cycles <= '0;
    end else if (take_start) begin
      stall_cycles  <= '0;
      starve_cycles <= '0;
    end else if (state == S_RUN) begin
      if (buf_valid && !out_ready && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (fifo_empty && (buf_occ == 2'd0) && (starve_cycles != 32'hFFFF_FFFF))
        starve_cycles <= starve_cycles + 32'd1;
    end
  end
`endif

endmodule
